// File: rtl/scan_display_ctrl.sv
// Multiplexed 4-digit 7-segment driver with a one-entry pending buffer that
// commits new readings only at frame boundaries, so a frame never mixes readings.
`timescale 1ns/1ps
module scan_display_ctrl #(
  parameter int SCAN_DIV = 1000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] dec0,
  input  logic [3:0] dec1,
  input  logic [3:0] dec2,
  input  logic [3:0] dec3,
  input  logic       over,
  input  logic       upd_valid,
  output logic       upd_ready,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_done
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // reading layout: {over, dec3, dec2, dec1, dec0}
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic          pend_full_q, pend_full_d;
  logic [16:0]   pend_q, pend_d;
  logic [16:0]   disp_q, disp_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          frame_done_q, frame_done_d;

  logic       tick, boundary, accept;
  logic [3:0] digit;
  logic       blank;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  always_comb begin
    tick     = (presc_q == PMAX);
    presc_d  = tick ? '0 : presc_q + PW'(1);
    idx_d    = tick ? idx_q + 2'd1 : idx_q;
    boundary = tick && (idx_q == 2'd3);
    accept   = upd_valid && !pend_full_q;

    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    disp_d      = disp_q;
    if (accept) begin
      pend_d      = {over, dec3, dec2, dec1, dec0};
      pend_full_d = 1'b1;
    end else if (boundary && pend_full_q) begin
      disp_d      = pend_q;
      pend_full_d = 1'b0;
    end
    frame_done_d = boundary;
  end

  // Outputs follow the current index one cycle later; digit 0 is never blanked.
  always_comb begin
    digit = 4'd0;
    blank = 1'b0;
    case (idx_q)
      2'd0: digit = disp_q[3:0];
      2'd1: begin
        digit = disp_q[7:4];
        blank = (disp_q[15:4] == 12'd0);
      end
      2'd2: begin
        digit = disp_q[11:8];
        blank = (disp_q[15:8] == 8'd0);
      end
      default: begin
        digit = disp_q[15:12];
        blank = (disp_q[15:12] == 4'd0);
      end
    endcase
    an_d = ~(4'b0001 << idx_q);
    if (disp_q[16])
      seg_d = SEG_DASH;
    else if (BLANK_LZ && blank)
      seg_d = SEG_BLANK;
    else
      seg_d = bcd_to_seg(digit);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q      <= '0;
      idx_q        <= 2'd0;
      pend_full_q  <= 1'b0;
      pend_q       <= '0;
      disp_q       <= '0;
      an_q         <= 4'b1111;
      seg_q        <= SEG_BLANK;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pend_full_q  <= pend_full_d;
      pend_q       <= pend_d;
      disp_q       <= disp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign upd_ready  = !pend_full_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Directed bench for scan_display_ctrl: one blanking and one non-blanking
// instance share stimulus; expected frames are queued and checked slot by slot.
`timescale 1ns/1ps
module tb_scan_display_ctrl;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] dec0 = '0, dec1 = '0, dec2 = '0, dec3 = '0;
  logic       over = 1'b0;
  logic       upd_valid = 1'b0;

  logic       ready_b, ready_n, fd_b, fd_n;
  logic [3:0] an_b, an_n;
  logic [6:0] seg_b, seg_n;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg_b;
    logic [6:0] seg_n;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  scan_display_ctrl #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) u_dut_b (
    .clk(clk), .reset(reset), .dec0(dec0), .dec1(dec1), .dec2(dec2), .dec3(dec3),
    .over(over), .upd_valid(upd_valid), .upd_ready(ready_b), .an(an_b), .seg(seg_b),
    .frame_done(fd_b));

  scan_display_ctrl #(.SCAN_DIV(SD), .BLANK_LZ(1'b0)) u_dut_n (
    .clk(clk), .reset(reset), .dec0(dec0), .dec1(dec1), .dec2(dec2), .dec3(dec3),
    .over(over), .upd_valid(upd_valid), .upd_ready(ready_n), .an(an_n), .seg(seg_n),
    .frame_done(fd_n));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      $error("%s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_ref(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [3:0] an_ref(input int k);
    case (k)
      0: return 4'b1110;
      1: return 4'b1101;
      2: return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  // leading digit k is blank when the whole value is below 10^k
  task automatic push_reading(input bit ov, input int d3, input int d2, input int d1, input int d0);
    int dig[4];
    int value;
    int pw;
    exp_t e;
    dig = '{d0, d1, d2, d3};
    value = d3 * 1000 + d2 * 100 + d1 * 10 + d0;
    pw = 1;
    for (int k = 0; k < 4; k++) begin
      e.an = an_ref(k);
      if (ov) begin
        e.seg_b = 7'b0111111;
        e.seg_n = 7'b0111111;
      end else begin
        e.seg_n = seg_ref(dig[k]);
        e.seg_b = (k > 0 && value < pw) ? 7'b1111111 : seg_ref(dig[k]);
      end
      sb.push_back(e);
      pw = pw * 10;
    end
  endtask

  task automatic drive(input bit ov, input int d3, input int d2, input int d1, input int d0);
    over = ov;
    dec3 = 4'(d3); dec2 = 4'(d2); dec1 = 4'(d1); dec0 = 4'(d0);
  endtask

  // called at a negedge; leaves at the negedge after the accepting edge
  task automatic offer(input string tag, input bit ov, input int d3, input int d2, input int d1, input int d0);
    drive(ov, d3, d2, d1, d0);
    upd_valid = 1'b1;
    @(negedge clk);
    upd_valid = 1'b0;
    chk({tag, "_ready_low"}, ready_b, 0);
  endtask

  task automatic wait_frame_done(input string tag);
    for (int i = 0; i < 20 * SD; i++) begin
      @(negedge clk);
      if (fd_b) break;
    end
    chk({tag, "_frame_done_seen"}, fd_b, 1);
  endtask

  // called at a frame_done negedge; samples all 4*SD cycles of the next frame
  task automatic check_frame(input string tag, input bit exp_ready_mid);
    exp_t e;
    for (int s = 0; s < 4; s++) begin
      if (sb.size() == 0) begin
        chk({tag, "_sb_underflow"}, 1, 0);
        return;
      end
      e = sb.pop_front();
      for (int c = 0; c < SD; c++) begin
        @(negedge clk);
        if (s == 0 && c == 0) upd_valid = 1'b0;
        chk($sformatf("%s_an_s%0d_c%0d", tag, s, c), an_b, e.an);
        chk($sformatf("%s_seg_s%0d_c%0d", tag, s, c), seg_b, e.seg_b);
        chk($sformatf("%s_segn_s%0d_c%0d", tag, s, c), seg_n, e.seg_n);
        if (s == 2 && c == 0) begin
          chk({tag, "_ready_mid"}, ready_b, 32'(exp_ready_mid));
          chk({tag, "_fd_mid"}, fd_b, 0);
        end
      end
    end
    chk({tag, "_fd_end"}, fd_b, 1);
  endtask

  initial begin
    // reset held for 3 cycles
    repeat (3) @(negedge clk);
    chk("rst_an", an_b, 4'b1111);
    chk("rst_seg", seg_b, 7'b1111111);
    chk("rst_ready", ready_b, 1);
    chk("rst_fd", fd_b, 0);
    chk("rst_an_n", an_n, 4'b1111);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_an", an_b, 4'b1110);
    chk("rel_seg", seg_b, 7'b1000000);
    chk("rel_seg_n", seg_n, 7'b1000000);

    push_reading(1'b0, 0, 0, 0, 0);
    wait_frame_done("init");
    check_frame("zero", 1'b1);

    offer("r1234", 1'b0, 1, 2, 3, 4);
    push_reading(1'b0, 1, 2, 3, 4);
    wait_frame_done("r1234");
    chk("r1234_ready_after_commit", ready_b, 1);
    check_frame("r1234", 1'b1);

    offer("r0042", 1'b0, 0, 0, 4, 2);
    push_reading(1'b0, 0, 0, 4, 2);
    wait_frame_done("r0042");
    check_frame("r0042", 1'b1);

    // back-to-back: 2222 held valid while 1111 is pending
    drive(1'b0, 1, 1, 1, 1);
    upd_valid = 1'b1;
    push_reading(1'b0, 1, 1, 1, 1);
    @(negedge clk);
    chk("b2b_ready_low", ready_b, 0);
    drive(1'b0, 2, 2, 2, 2);
    push_reading(1'b0, 2, 2, 2, 2);
    wait_frame_done("b2b");
    chk("b2b_ready_commit1", ready_b, 1);
    check_frame("b2b_1111", 1'b0);
    chk("b2b_ready_commit2", ready_b, 1);
    check_frame("b2b_2222", 1'b1);

    offer("over", 1'b1, 5, 6, 7, 8);
    push_reading(1'b1, 5, 6, 7, 8);
    wait_frame_done("over");
    check_frame("over", 1'b1);

    offer("r0007", 1'b0, 0, 0, 0, 7);
    push_reading(1'b0, 0, 0, 0, 7);
    wait_frame_done("r0007");
    check_frame("r0007", 1'b1);

    // reset mid-frame with a reading pending; 9999 must never appear
    offer("discard", 1'b0, 9, 9, 9, 9);
    for (int i = 0; i < 8 * SD; i++) begin
      if (an_b == 4'b1011) break;
      @(negedge clk);
    end
    chk("mid_idx2_seen", an_b, 4'b1011);
    chk("mid_pend_full", ready_b, 0);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_an", an_b, 4'b1111);
    chk("mid_rst_seg", seg_b, 7'b1111111);
    chk("mid_rst_ready", ready_b, 1);
    chk("mid_rst_fd", fd_b, 0);
    chk("mid_rst_seg_n", seg_n, 7'b1111111);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rel_an", an_b, 4'b1110);
    chk("mid_rel_seg", seg_b, 7'b1000000);
    chk("mid_rel_ready", ready_b, 1);
    push_reading(1'b0, 0, 0, 0, 0);
    wait_frame_done("mid");
    check_frame("mid_zero", 1'b1);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
